wired_npc_gen: RTL and testbench

- Fetch-PC generator at the head of the frontend. It produces one 8-byte fetch packet per handshake: aligned PC, 2-bit slot mask, per-slot prediction and epoch tid.
- It feeds the W->F skid buffer ahead of the icache.
- A small direct-mapped BTB, trained from backend corrections, steers the next PC.
- Backend redirects override everything and advance the epoch tid, which the B stage uses to discard stale packets.

---
 rtl/wired0_defines.sv | 38 +++
 rtl/wired_npc_btb.sv | 63 ++++++
 rtl/wired_npc_gen.sv | 111 +++++++++++
 tb/tb_wired_npc_gen.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wired0_defines.sv
// Shared types for the fetch-PC generator: BTB entry, fetch packet and backend correction bundle.
package wired0_defines;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam int unsigned NPC_TID_W        = 1;
    localparam int unsigned NPC_TAG_W        = 29;

    typedef struct packed {
        logic                 valid;
        logic [NPC_TAG_W-1:0] tag;
        logic                 slot;
        logic [29:0]          target;
    } npc_btb_entry_t;

    typedef struct packed {
        logic [31:0]          pc;
        logic [1:0]           mask;
        logic [1:0]           taken;
        logic [31:0]          target;
        logic [NPC_TID_W-1:0] tid;
    } fetch_pkt_t;

    typedef struct packed {
        logic                 redirect;
        logic [NPC_TID_W-1:0] tid;
        logic [31:0]          pc;
        logic                 upd_valid;
        logic [31:0]          upd_pc;
        logic                 upd_taken;
        logic [31:0]          upd_target;
    } bpu_correct_t;

    // Tag is everything above the index; stored zero-extended so one entry type fits any table size.
    function automatic logic [NPC_TAG_W-1:0] btb_tag(input logic [31:0] pc, input int unsigned idx_w);
        return NPC_TAG_W'(pc >> (idx_w + 32'd3));
    endfunction

endpackage

// File: rtl/wired_npc_btb.sv
// Direct-mapped branch target buffer: flop storage, asynchronous lookup, one training write port.
module wired_npc_btb
    import wired0_defines::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        slot,
    output logic [31:0] target,
    input  logic        wr_valid,
    input  logic [31:0] wr_pc,
    input  logic        wr_taken,
    input  logic [31:0] wr_target
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    npc_btb_entry_t       table_r [ENTRIES];
    npc_btb_entry_t       rd_entry_s;
    logic [IDX-1:0]       rd_idx_s;
    logic [IDX-1:0]       wr_idx_s;
    logic [NPC_TAG_W-1:0] rd_tag_s;
    logic [NPC_TAG_W-1:0] wr_tag_s;

    assign rd_idx_s   = lookup_pc[IDX+2:3];
    assign wr_idx_s   = wr_pc[IDX+2:3];
    assign rd_tag_s   = btb_tag(lookup_pc, IDX);
    assign wr_tag_s   = btb_tag(wr_pc, IDX);
    assign rd_entry_s = table_r[rd_idx_s];

    // Lookup: a branch behind the fetch point within the packet does not count as a hit.
    always_comb begin
        hit    = 1'b0;
        slot   = 1'b0;
        target = 32'h0000_0000;
        if (rd_entry_s.valid && (rd_entry_s.tag == rd_tag_s) && (rd_entry_s.slot >= lookup_pc[2])) begin
            hit    = 1'b1;
            slot   = rd_entry_s.slot;
            target = {rd_entry_s.target, 2'b00};
        end else begin
            hit    = 1'b0;
        end
    end

    // Training write; not-taken only evicts the entry that actually belongs to this branch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                table_r[i] <= '0;
            end
        end else if (wr_valid) begin
            if (wr_taken) begin
                table_r[wr_idx_s] <= '{valid: 1'b1, tag: wr_tag_s, slot: wr_pc[2], target: wr_target[31:2]};
            end else if ((table_r[wr_idx_s].tag == wr_tag_s) && (table_r[wr_idx_s].slot == wr_pc[2])) begin
                table_r[wr_idx_s].valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/wired_npc_gen.sv
// Fetch-PC generator: emits one 8-byte fetch packet per handshake, steered by the BTB and backend redirects.
module wired_npc_gen
    import wired0_defines::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned BTB_ENTRIES = 64,
    parameter int unsigned TID_WIDTH   = NPC_TID_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 redirect_i,
    input  logic [31:0]          redirect_pc_i,
    input  logic [TID_WIDTH-1:0] redirect_tid_i,
    input  logic                 upd_valid_i,
    input  logic [31:0]          upd_pc_i,
    input  logic                 upd_taken_i,
    input  logic [31:0]          upd_target_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [31:0]          pc_o,
    output logic [1:0]           mask_o,
    output logic [1:0]           taken_o,
    output logic [31:0]          target_o,
    output logic [TID_WIDTH-1:0] tid_o
);

    bpu_correct_t         correct_s;
    fetch_pkt_t           pkt_s;
    logic [31:0]          pc_r;
    logic [TID_WIDTH-1:0] tid_r;
    logic                 run_r;
    logic                 valid_s;
    logic                 btb_hit_s;
    logic                 btb_slot_s;
    logic [31:0]          btb_target_s;
    logic [1:0]           base_mask_s;
    logic [31:0]          next_pc_s;

    assign correct_s = '{
        redirect:   redirect_i,
        tid:        NPC_TID_W'(redirect_tid_i),
        pc:         redirect_pc_i,
        upd_valid:  upd_valid_i,
        upd_pc:     upd_pc_i,
        upd_taken:  upd_taken_i,
        upd_target: upd_target_i
    };

    wired_npc_btb #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .rst_n     (rst_n),
        .lookup_pc (pc_r),
        .hit       (btb_hit_s),
        .slot      (btb_slot_s),
        .target    (btb_target_s),
        .wr_valid  (correct_s.upd_valid),
        .wr_pc     (correct_s.upd_pc),
        .wr_taken  (correct_s.upd_taken),
        .wr_target (correct_s.upd_target)
    );

    // A redirect kills the packet in its own cycle; a reset cycle never emits.
    assign valid_s     = run_r & rst_n & ~correct_s.redirect;
    assign base_mask_s = pc_r[2] ? 2'b10 : 2'b11;

    // Packet assembly and next-PC selection; the sequential fallthrough wraps within 29 bits.
    always_comb begin
        pkt_s     = '0;
        next_pc_s = 32'h0000_0000;
        pkt_s.pc  = pc_r;
        pkt_s.tid = NPC_TID_W'(tid_r);
        if (btb_hit_s) begin
            pkt_s.mask   = btb_slot_s ? base_mask_s : (base_mask_s & 2'b01);
            pkt_s.taken  = btb_slot_s ? 2'b10 : 2'b01;
            pkt_s.target = btb_target_s;
            next_pc_s    = btb_target_s;
        end else begin
            pkt_s.mask   = base_mask_s;
            pkt_s.taken  = 2'b00;
            pkt_s.target = 32'h0000_0000;
            next_pc_s    = {pc_r[31:3] + 29'd1, 3'b000};
        end
    end

    assign valid_o  = valid_s;
    assign pc_o     = pkt_s.pc;
    assign mask_o   = pkt_s.mask;
    assign taken_o  = pkt_s.taken;
    assign target_o = pkt_s.target;
    assign tid_o    = TID_WIDTH'(pkt_s.tid);

    // PC/epoch state: redirect beats the handshake and ignores ready_i.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_r  <= RESET_PC;
            tid_r <= '0;
            run_r <= 1'b0;
        end else begin
            run_r <= 1'b1;
            if (correct_s.redirect) begin
                pc_r  <= correct_s.pc;
                tid_r <= TID_WIDTH'(correct_s.tid);
            end else if (valid_s && ready_i) begin
                pc_r  <= next_pc_s;
            end
        end
    end

endmodule

// File: tb/tb_wired_npc_gen.sv
// Directed self-checking bench for wired_npc_gen; expected packets are hand-computed constants.
module tb_wired_npc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [0:0]  redirect_tid_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic [31:0] upd_target_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [1:0]  mask_o;
    logic [1:0]  taken_o;
    logic [31:0] target_o;
    logic [0:0]  tid_o;

    int          tests_run = 0;
    int          failed    = 0;
    logic [69:0] exp_v;

    wired_npc_gen dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .redirect_tid_i (redirect_tid_i),
        .upd_valid_i    (upd_valid_i),
        .upd_pc_i       (upd_pc_i),
        .upd_taken_i    (upd_taken_i),
        .upd_target_i   (upd_target_i),
        .ready_i        (ready_i),
        .valid_o        (valid_o),
        .pc_o           (pc_o),
        .mask_o         (mask_o),
        .taken_o        (taken_o),
        .target_o       (target_o),
        .tid_o          (tid_o)
    );

    always #5 clk = ~clk;

    // Packed view of the packet: {valid, pc, mask, taken, target, tid}.
    function automatic logic [69:0] obs();
        return {valid_o, pc_o, mask_o, taken_o, target_o, tid_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic tid);
        redirect_i     = 1'b1;
        redirect_pc_i  = pc;
        redirect_tid_i = tid;
        step();
        redirect_i     = 1'b0;
        #1;
    endtask

    task automatic do_train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid_i  = 1'b1;
        upd_pc_i     = pc;
        upd_taken_i  = taken;
        upd_target_i = tgt;
        step();
        upd_valid_i  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ready_i = 1'b1;
        step();
        step();
        exp_v = {1'b0, 32'h1c00_0000, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL reset_hold: got %h expected %h", obs(), exp_v); end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL reset_first_cycle: got %h expected %h", obs(), exp_v); end
        step();
        exp_v = {1'b1, 32'h1c00_0000, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL reset_first_pkt: got %h expected %h", obs(), exp_v); end
        step();
        exp_v = {1'b1, 32'h1c00_0008, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL seq_second_pkt: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_stall();
        ready_i = 1'b0;
        exp_v = {1'b1, 32'h1c00_0008, 2'b11, 2'b00, 32'h0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (obs() !== exp_v) begin failed++; $display("FAIL stall_hold[%0d]: got %h expected %h", i, obs(), exp_v); end
        end
        ready_i = 1'b1;
        step();
        exp_v = {1'b1, 32'h1c00_0010, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL stall_release: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_redirect();
        ready_i        = 1'b0;
        redirect_i     = 1'b1;
        redirect_pc_i  = 32'h1c00_0104;
        redirect_tid_i = 1'b1;
        #1;
        exp_v = {1'b0, 32'h1c00_0010, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL redirect_kill: got %h expected %h", obs(), exp_v); end
        step();
        redirect_i = 1'b0;
        #1;
        exp_v = {1'b1, 32'h1c00_0104, 2'b10, 2'b00, 32'h0, 1'b1};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL redirect_target: got %h expected %h", obs(), exp_v); end
        ready_i = 1'b1;
        step();
        exp_v = {1'b1, 32'h1c00_0108, 2'b11, 2'b00, 32'h0, 1'b1};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL redirect_follow: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_btb_taken();
        ready_i = 1'b0;
        do_train(32'h1c00_0010, 1'b1, 32'h1c00_0040);
        do_redirect(32'h1c00_0010, 1'b0);
        exp_v = {1'b1, 32'h1c00_0010, 2'b01, 2'b01, 32'h1c00_0040, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_hit_slot0: got %h expected %h", obs(), exp_v); end
        ready_i = 1'b1;
        step();
        exp_v = {1'b1, 32'h1c00_0040, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_taken_next: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_btb_miss_untrain();
        ready_i = 1'b0;
        do_redirect(32'h1c00_0014, 1'b0);
        exp_v = {1'b1, 32'h1c00_0014, 2'b10, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_behind_slot: got %h expected %h", obs(), exp_v); end
        ready_i = 1'b1;
        step();
        exp_v = {1'b1, 32'h1c00_0018, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_behind_next: got %h expected %h", obs(), exp_v); end
        ready_i = 1'b0;
        do_train(32'h1c00_0010, 1'b0, 32'h0);
        do_redirect(32'h1c00_0010, 1'b0);
        exp_v = {1'b1, 32'h1c00_0010, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_untrained: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_slot1_and_tag();
        ready_i = 1'b0;
        do_train(32'h1c00_002c, 1'b1, 32'h1c00_0200);
        do_redirect(32'h1c00_0028, 1'b0);
        exp_v = {1'b1, 32'h1c00_0028, 2'b11, 2'b10, 32'h1c00_0200, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_hit_slot1: got %h expected %h", obs(), exp_v); end
        do_redirect(32'h1c00_002c, 1'b0);
        exp_v = {1'b1, 32'h1c00_002c, 2'b10, 2'b10, 32'h1c00_0200, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_hit_slot1_upper: got %h expected %h", obs(), exp_v); end
        do_redirect(32'h1c00_0428, 1'b0);
        exp_v = {1'b1, 32'h1c00_0428, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL btb_tag_mismatch: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_same_cycle_train();
        ready_i = 1'b0;
        do_redirect(32'h1c00_0028, 1'b0);
        upd_valid_i  = 1'b1;
        upd_pc_i     = 32'h1c00_0028;
        upd_taken_i  = 1'b1;
        upd_target_i = 32'h1c00_0300;
        #1;
        exp_v = {1'b1, 32'h1c00_0028, 2'b11, 2'b10, 32'h1c00_0200, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL same_cycle_old: got %h expected %h", obs(), exp_v); end
        step();
        upd_valid_i = 1'b0;
        #1;
        exp_v = {1'b1, 32'h1c00_0028, 2'b01, 2'b01, 32'h1c00_0300, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL same_cycle_new: got %h expected %h", obs(), exp_v); end
        ready_i = 1'b1;
        step();
        exp_v = {1'b1, 32'h1c00_0300, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL same_cycle_next: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_back_to_back();
        ready_i        = 1'b1;
        redirect_i     = 1'b1;
        redirect_pc_i  = 32'h1c00_0500;
        redirect_tid_i = 1'b1;
        step();
        redirect_pc_i  = 32'h1c00_0600;
        redirect_tid_i = 1'b0;
        #1;
        exp_v = {1'b0, 32'h1c00_0500, 2'b11, 2'b00, 32'h0, 1'b1};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL b2b_first: got %h expected %h", obs(), exp_v); end
        step();
        redirect_i = 1'b0;
        #1;
        exp_v = {1'b1, 32'h1c00_0600, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL b2b_last_wins: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_wrap();
        ready_i = 1'b1;
        do_redirect(32'hffff_fff8, 1'b1);
        exp_v = {1'b1, 32'hffff_fff8, 2'b11, 2'b00, 32'h0, 1'b1};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL wrap_top: got %h expected %h", obs(), exp_v); end
        step();
        exp_v = {1'b1, 32'h0000_0000, 2'b11, 2'b00, 32'h0, 1'b1};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL wrap_zero: got %h expected %h", obs(), exp_v); end
    endtask

    task automatic test_mid_reset();
        ready_i = 1'b1;
        rst_n   = 1'b0;
        #1;
        exp_v = {1'b0, 32'h0000_0000, 2'b11, 2'b00, 32'h0, 1'b1};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL midreset_kill: got %h expected %h", obs(), exp_v); end
        step();
        exp_v = {1'b0, 32'h1c00_0000, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL midreset_state: got %h expected %h", obs(), exp_v); end
        rst_n = 1'b1;
        step();
        exp_v = {1'b1, 32'h1c00_0000, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL midreset_restart: got %h expected %h", obs(), exp_v); end
        ready_i = 1'b0;
        do_redirect(32'h1c00_0028, 1'b0);
        exp_v = {1'b1, 32'h1c00_0028, 2'b11, 2'b00, 32'h0, 1'b0};
        tests_run++;
        if (obs() !== exp_v) begin failed++; $display("FAIL midreset_btb_clear: got %h expected %h", obs(), exp_v); end
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_i     = 1'b0;
        redirect_pc_i  = 32'h0;
        redirect_tid_i = 1'b0;
        upd_valid_i    = 1'b0;
        upd_pc_i       = 32'h0;
        upd_taken_i    = 1'b0;
        upd_target_i   = 32'h0;
        ready_i        = 1'b0;
        test_reset();
        test_stall();
        test_redirect();
        test_btb_taken();
        test_btb_miss_untrain();
        test_slot1_and_tag();
        test_same_cycle_train();
        test_back_to_back();
        test_wrap();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
